// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array phase sequencer.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      COMP  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } seq_state_t;

   // Cycles needed for data to ripple fully through an N x N systolic array.
   function automatic int comp_cycles(input int array_size);
      return 3 * array_size - 2;
   endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// Loadable down-counter with a zero flag; stops at zero until reloaded.
module seq_phase_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/systolic_sequencer.sv
// Multi-tile read -> compute -> write phase sequencer for the systolic array.
// Optional per-phase watchdog enabled by defining SYSTOLIC_SEQ_TMO_EN.
module systolic_sequencer
   import systolic_pkg::*;
#(
   parameter int               ARRAY_SIZE = 2,
   parameter int               TILE_W     = 8,
   parameter int               TMO_W      = 16,
   parameter logic [TMO_W-1:0] TMO_MAX    = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tpu_start,
   input  logic [TILE_W-1:0] num_tiles,
   input  logic              abort,
   input  logic              rempty,
   input  logic              wfull,
   input  logic              read_done,
   input  logic              write_done,
   output logic              read_start,
   output logic              compute_start,
   output logic              write_start,
   output logic              busy,
   output logic [TILE_W-1:0] tile_idx,
   output logic              tpu_done,
   output logic              error
);

   localparam int               COMP_W    = $clog2(3 * ARRAY_SIZE);
   localparam logic [COMP_W-1:0] COMP_LOAD = COMP_W'(comp_cycles(ARRAY_SIZE) - 1);

   seq_state_t        state;
   logic [TILE_W-1:0] tiles_q;
   logic [COMP_W-1:0] comp_cnt_unused;
   logic              comp_zero;
   logic              read_go;
   logic              write_go;
   logic              last_tile;
   logic              timeout;

   // Strobes are gated by FIFO status in the same cycle; a phase only
   // completes while its strobe is actually asserted.
   assign read_start    = (state == READ) && !rempty;
   assign compute_start = (state == COMP);
   assign write_start   = (state == WRITE) && !wfull;
   assign busy          = (state != IDLE);
   assign tpu_done      = (state == DONE);

   assign read_go   = read_start && read_done;
   assign write_go  = write_start && write_done;
   assign last_tile = (tile_idx == tiles_q - TILE_W'(1));

   seq_phase_timer #(.W(COMP_W)) u_comp_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (read_go && !abort),
      .load_val (COMP_LOAD),
      .dec      (compute_start),
      .count    (comp_cnt_unused),
      .zero     (comp_zero)
   );

`ifdef SYSTOLIC_SEQ_TMO_EN
   localparam logic [TMO_W-1:0] WD_LOAD = TMO_MAX - 1'b1;

   logic [TMO_W-1:0] wd_cnt_unused;
   logic             wd_zero;
   logic             wd_active;
   logic             wd_load;
   logic             error_q;

   assign wd_active = (state == READ) || (state == WRITE);
   // Reload on every entry into READ or WRITE.
   assign wd_load   = !abort && (((state == IDLE) && tpu_start && (num_tiles != '0))
                              || ((state == COMP) && comp_zero)
                              || (write_go && !last_tile));
   assign timeout   = wd_active && wd_zero && !read_go && !write_go && !abort;

   seq_phase_timer #(.W(TMO_W)) u_wd_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (wd_load),
      .load_val (WD_LOAD),
      .dec      (wd_active),
      .count    (wd_cnt_unused),
      .zero     (wd_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error_q <= 1'b0;
      end else if ((state == IDLE) && tpu_start) begin
         error_q <= 1'b0;
      end else if (timeout) begin
         error_q <= 1'b1;
      end
   end

   assign error = error_q;
`else
   // Watchdog parameters stay on the interface so both builds share one instantiation.
   localparam int tmo_params_unused = TMO_W + int'(TMO_MAX[0]);

   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tiles_q  <= '0;
         tile_idx <= '0;
      end else if (abort && (state != IDLE)) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (tpu_start) begin
                  if (num_tiles != '0) begin
                     tiles_q  <= num_tiles;
                     tile_idx <= '0;
                     state    <= READ;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            READ: begin
               if (read_go) begin
                  state <= COMP;
               end else if (timeout) begin
                  state <= DONE;
               end
            end
            COMP: begin
               if (comp_zero) begin
                  state <= WRITE;
               end
            end
            WRITE: begin
               if (write_go) begin
                  if (last_tile) begin
                     state <= DONE;
                  end else begin
                     tile_idx <= tile_idx + 1'b1;
                     state    <= READ;
                  end
               end else if (timeout) begin
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
